// File: rtl/axi_pkg.sv
// Shared types for the two-master AXI read arbiter: AR request, R beat and FSM states.
package axi_pkg;

  localparam int unsigned AXI_ID_W    = 13;
  localparam int unsigned AXI_ADDR_W  = 64;
  localparam int unsigned AXI_DATA_W  = 64;
  localparam int unsigned AXI_LEN_W   = 8;
  localparam int unsigned AXI_SIZE_W  = 3;
  localparam int unsigned AXI_BURST_W = 2;
  localparam int unsigned AXI_PROT_W  = 3;
  localparam int unsigned AXI_RESP_W  = 2;

  typedef struct packed {
    logic [AXI_ID_W-1:0]    id;
    logic [AXI_ADDR_W-1:0]  addr;
    logic [AXI_LEN_W-1:0]   len;
    logic [AXI_SIZE_W-1:0]  size;
    logic [AXI_BURST_W-1:0] burst;
    logic [AXI_PROT_W-1:0]  prot;
  } ar_req_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_RESP_W-1:0] resp;
    logic                  last;
  } r_beat_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the prio index.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_prio,
  output logic       o_gnt_c,
  output logic       o_valid_c
);

  always_comb begin
    o_valid_c = |i_req;
    o_gnt_c   = 1'b0;
    case (i_req)
      2'b01:   o_gnt_c = 1'b0;
      2'b10:   o_gnt_c = 1'b1;
      2'b11:   o_gnt_c = i_prio;
      default: o_gnt_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one downstream AXI read port between the Icache (m0) and Dcache (m1) refill masters,
// one burst at a time, and flags bursts whose rlast disagrees with arlen.
module axi_rd_arbiter
  import axi_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = AXI_ID_W,
  parameter int unsigned ADDR_WIDTH = AXI_ADDR_W,
  parameter int unsigned DATA_WIDTH = AXI_DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ID_WIDTH-1:0]   m0_arid,
  input  logic [ADDR_WIDTH-1:0] m0_araddr,
  input  logic [7:0]            m0_arlen,
  input  logic [2:0]            m0_arsize,
  input  logic [1:0]            m0_arburst,
  input  logic [2:0]            m0_arprot,
  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  output logic [ID_WIDTH-1:0]   m0_rid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [1:0]            m0_rresp,
  output logic                  m0_rlast,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,
  input  logic [ID_WIDTH-1:0]   m1_arid,
  input  logic [ADDR_WIDTH-1:0] m1_araddr,
  input  logic [7:0]            m1_arlen,
  input  logic [2:0]            m1_arsize,
  input  logic [1:0]            m1_arburst,
  input  logic [2:0]            m1_arprot,
  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  output logic [ID_WIDTH-1:0]   m1_rid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [1:0]            m1_rresp,
  output logic                  m1_rlast,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,
  output logic [ID_WIDTH-1:0]   s_arid,
  output logic [ADDR_WIDTH-1:0] s_araddr,
  output logic [7:0]            s_arlen,
  output logic [2:0]            s_arsize,
  output logic [1:0]            s_arburst,
  output logic [2:0]            s_arprot,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  input  logic [ID_WIDTH-1:0]   s_rid,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rlast,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  output logic                  busy,
  output logic                  grant,
  output logic                  len_err
);

  state_t                 r_state;
  logic                   r_prio;
  logic                   r_grant;
  logic                   r_len_err;
  logic [AXI_LEN_W-1:0]   r_beat_cnt;
  logic                   r_arvalid;
  ar_req_t                r_ar;

  ar_req_t                w_req0;
  ar_req_t                w_req1;
  ar_req_t                w_sel;
  r_beat_t                w_beat;
  r_beat_t                w_beat0;
  r_beat_t                w_beat1;
  logic [1:0]             w_req;
  logic                   w_gnt;
  logic                   w_gnt_vld;
  logic                   w_idle;
  logic                   w_data;
  logic                   w_take;
  logic                   w_mg_rready;
  logic                   w_hs;

  assign w_req = {m1_arvalid, m0_arvalid};

  rr_arb2 u_rr_arb2 (
    .i_req     (w_req),
    .i_prio    (r_prio),
    .o_gnt_c   (w_gnt),
    .o_valid_c (w_gnt_vld)
  );

  // Combinational paths are gated by reset so nothing leaks out while the FSM is being cleared.
  assign w_idle = (r_state == IDLE) && !reset;
  assign w_data = (r_state == DATA) && !reset;
  assign w_take = w_idle && w_gnt_vld;

  assign m0_arready = w_take && !w_gnt;
  assign m1_arready = w_take &&  w_gnt;

  always_comb begin
    w_req0.id    = AXI_ID_W'(m0_arid);
    w_req0.addr  = AXI_ADDR_W'(m0_araddr);
    w_req0.len   = m0_arlen;
    w_req0.size  = m0_arsize;
    w_req0.burst = m0_arburst;
    w_req0.prot  = m0_arprot;
    w_req1.id    = AXI_ID_W'(m1_arid);
    w_req1.addr  = AXI_ADDR_W'(m1_araddr);
    w_req1.len   = m1_arlen;
    w_req1.size  = m1_arsize;
    w_req1.burst = m1_arburst;
    w_req1.prot  = m1_arprot;
    w_sel        = w_gnt ? w_req1 : w_req0;
  end

  // R channel is a zero-latency steer toward the granted master; the other side reads zeros.
  always_comb begin
    w_beat.id   = AXI_ID_W'(s_rid);
    w_beat.data = AXI_DATA_W'(s_rdata);
    w_beat.resp = s_rresp;
    w_beat.last = s_rlast;
    w_beat0     = (w_data && !r_grant) ? w_beat : '0;
    w_beat1     = (w_data &&  r_grant) ? w_beat : '0;
  end

  assign w_mg_rready = r_grant ? m1_rready : m0_rready;
  assign s_rready    = w_data && w_mg_rready;
  assign w_hs        = s_rvalid && s_rready;

  assign m0_rvalid = w_data && !r_grant && s_rvalid;
  assign m0_rid    = ID_WIDTH'(w_beat0.id);
  assign m0_rdata  = DATA_WIDTH'(w_beat0.data);
  assign m0_rresp  = w_beat0.resp;
  assign m0_rlast  = w_beat0.last;

  assign m1_rvalid = w_data && r_grant && s_rvalid;
  assign m1_rid    = ID_WIDTH'(w_beat1.id);
  assign m1_rdata  = DATA_WIDTH'(w_beat1.data);
  assign m1_rresp  = w_beat1.resp;
  assign m1_rlast  = w_beat1.last;

  assign s_arid    = ID_WIDTH'(r_ar.id);
  assign s_araddr  = ADDR_WIDTH'(r_ar.addr);
  assign s_arlen   = r_ar.len;
  assign s_arsize  = r_ar.size;
  assign s_arburst = r_ar.burst;
  assign s_arprot  = r_ar.prot;
  assign s_arvalid = r_arvalid;

  assign busy    = (r_state != IDLE) && !reset;
  assign grant   = r_grant;
  assign len_err = r_len_err;

  // Grant, hold the AR until accepted, then count beats until the rlast handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_prio     <= 1'b0;
      r_grant    <= 1'b0;
      r_len_err  <= 1'b0;
      r_beat_cnt <= '0;
      r_arvalid  <= 1'b0;
      r_ar       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt_vld) begin
            r_ar       <= w_sel;
            r_grant    <= w_gnt;
            r_beat_cnt <= '0;
            r_arvalid  <= 1'b1;
            r_state    <= ADDR;
          end
        end
        ADDR: begin
          if (s_arready) begin
            r_arvalid <= 1'b0;
            r_state   <= DATA;
          end
        end
        DATA: begin
          if (w_hs) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
            if (s_rlast) begin
              if (r_beat_cnt != r_ar.len) begin
                r_len_err <= 1'b1;
              end
              r_prio  <= ~r_grant;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: bench plays both cache masters and the memory slave.
module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] m0_arid,    m1_arid;
  logic [63:0] m0_araddr,  m1_araddr;
  logic [7:0]  m0_arlen,   m1_arlen;
  logic [2:0]  m0_arsize,  m1_arsize;
  logic [1:0]  m0_arburst, m1_arburst;
  logic [2:0]  m0_arprot,  m1_arprot;
  logic        m0_arvalid, m1_arvalid;
  logic        m0_arready, m1_arready;
  logic [12:0] m0_rid,     m1_rid;
  logic [63:0] m0_rdata,   m1_rdata;
  logic [1:0]  m0_rresp,   m1_rresp;
  logic        m0_rlast,   m1_rlast;
  logic        m0_rvalid,  m1_rvalid;
  logic        m0_rready,  m1_rready;
  logic [12:0] s_arid;
  logic [63:0] s_araddr;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic [2:0]  s_arprot;
  logic        s_arvalid, s_arready;
  logic [12:0] s_rid;
  logic [63:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast, s_rvalid, s_rready;
  logic        busy, grant, len_err;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] rx0[$];
  logic [63:0] rx1[$];
  int arv_cycles, ar_seen, bad_rv, rr_err, pt_err;
  bit addr_moved;

  always #5 clk = ~clk;

  axi_rd_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_arid(m0_arid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
    .m0_arburst(m0_arburst), .m0_arprot(m0_arprot), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rid(m0_rid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_arid(m1_arid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
    .m1_arburst(m1_arburst), .m1_arprot(m1_arprot), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rid(m1_rid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid),
    .s_rready(s_rready), .busy(busy), .grant(grant), .len_err(len_err)
  );

  task automatic clear_inputs();
    m0_arid = '0; m0_araddr = '0; m0_arlen = '0; m0_arsize = '0; m0_arburst = '0; m0_arprot = '0;
    m1_arid = '0; m1_araddr = '0; m1_arlen = '0; m1_arsize = '0; m1_arburst = '0; m1_arprot = '0;
    m0_arvalid = 1'b0; m1_arvalid = 1'b0; m0_rready = 1'b0; m1_rready = 1'b0;
    s_arready = 1'b0; s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0; s_rvalid = 1'b0;
  endtask

  // Leaves the bench at a falling edge with reset just released.
  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic request(input int m, input logic [12:0] id, input logic [63:0] addr, input logic [7:0] len);
    if (m == 0) begin
      m0_arid = id; m0_araddr = addr; m0_arlen = len; m0_arsize = 3'd3; m0_arburst = 2'b01;
      m0_arprot = 3'($urandom_range(0, 7)); m0_arvalid = 1'b1;
    end else begin
      m1_arid = id; m1_araddr = addr; m1_arlen = len; m1_arsize = 3'd3; m1_arburst = 2'b01;
      m1_arprot = 3'($urandom_range(0, 7)); m1_arvalid = 1'b1;
    end
  endtask

  // Memory-side slave for one granted burst (entered in the AR-hold cycle); records what the masters saw.
  task automatic serve(input int em, input int ar_delay, input int nbeats, input int lo, input int hi,
                       input logic [63:0] dbase, input bit toggle_other, input bit gaps);
    logic [63:0] a0;
    logic        rdy, hs;
    int          b, sc, cyc;
    rx0.delete(); rx1.delete();
    arv_cycles = 0; ar_seen = 0; bad_rv = 0; rr_err = 0; pt_err = 0; addr_moved = 1'b0;
    a0 = s_araddr;
    for (int i = 0; i <= ar_delay; i++) begin
      s_arready = (i == ar_delay);
      if (toggle_other) begin
        if (em == 0) m1_arvalid = ~m1_arvalid; else m0_arvalid = ~m0_arvalid;
      end
      #1;
      if (s_arvalid === 1'b1) arv_cycles++;
      if (s_araddr !== a0) addr_moved = 1'b1;
      if (m0_arready !== 1'b0 || m1_arready !== 1'b0) ar_seen++;
      @(negedge clk);
    end
    s_arready = 1'b0;
    if (toggle_other) begin
      if (em == 0) m1_arvalid = 1'b0; else m0_arvalid = 1'b0;
    end
    b = 0; sc = 0; cyc = 0;
    while (b < nbeats && cyc < 400) begin
      s_rvalid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_rdata  = dbase + 64'(b);
      s_rlast  = (b == nbeats - 1);
      s_rid    = 13'($urandom);
      s_rresp  = 2'($urandom_range(0, 3));
      rdy      = !(b >= lo && b <= hi && sc < 2);
      if (em == 0) begin m0_rready = rdy; m1_rready = 1'($urandom_range(0, 1)); end
      else         begin m1_rready = rdy; m0_rready = 1'($urandom_range(0, 1)); end
      #1;
      if ((em == 0 ? m1_rvalid : m0_rvalid) !== 1'b0) bad_rv++;
      if (s_rready !== rdy) rr_err++;
      if ((em == 0 ? m0_rvalid : m1_rvalid) !== s_rvalid) pt_err++;
      if (m0_rvalid === 1'b1 && (m0_rlast !== s_rlast || m0_rid !== s_rid || m0_rresp !== s_rresp)) pt_err++;
      if (m1_rvalid === 1'b1 && (m1_rlast !== s_rlast || m1_rid !== s_rid || m1_rresp !== s_rresp)) pt_err++;
      if (m0_arready !== 1'b0 || m1_arready !== 1'b0) ar_seen++;
      if (m0_rvalid === 1'b1 && m0_rready) rx0.push_back(m0_rdata);
      if (m1_rvalid === 1'b1 && m1_rready) rx1.push_back(m1_rdata);
      hs = s_rvalid && (s_rready === 1'b1);
      if (s_rvalid) sc++;
      @(negedge clk);
      if (hs) begin b++; sc = 0; end
      cyc++;
    end
    s_rvalid = 1'b0; s_rlast = 1'b0;
    if (cyc >= 400) begin
      n_cmp++; n_err++;
      $display("FAIL serve_timeout: delivered %0d beats, required %0d", b, nbeats);
    end
  endtask

  // Number of wrong, missing or extra beats received by master w against base, base+1, ...
  function automatic int rx_bad(input int w, input logic [63:0] base, input int n);
    int bad;
    int sz;
    bad = 0;
    sz = (w == 0) ? rx0.size() : rx1.size();
    if (sz != n) bad += (sz > n) ? sz - n : n - sz;
    for (int i = 0; i < n && i < sz; i++) begin
      if (((w == 0) ? rx0[i] : rx1[i]) !== base + 64'(i)) bad++;
    end
    return bad;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    m0_arvalid = 1'b1; m1_arvalid = 1'b1; m0_rready = 1'b1; m1_rready = 1'b1; s_rvalid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (m0_arready !== 1'b0 || m1_arready !== 1'b0)
      begin n_err++; $display("FAIL reset_arready: got %b%b, required 00", m1_arready, m0_arready); end
    n_cmp++; if (s_rready !== 1'b0 || m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0)
      begin n_err++; $display("FAIL reset_r_handshake: s_rready=%b m0_rvalid=%b m1_rvalid=%b, required 0", s_rready, m0_rvalid, m1_rvalid); end
    clear_inputs();
    reset = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || grant !== 1'b0 || len_err !== 1'b0 || s_arvalid !== 1'b0)
      begin n_err++; $display("FAIL reset_status: busy=%b grant=%b len_err=%b s_arvalid=%b, required 0", busy, grant, len_err, s_arvalid); end
    n_cmp++; if (s_araddr !== 64'd0 || s_arid !== 13'd0 || s_arlen !== 8'd0)
      begin n_err++; $display("FAIL reset_s_ar: addr=%h id=%h len=%h, required 0", s_araddr, s_arid, s_arlen); end
  endtask

  task automatic test_single_m0();
    int bad;
    do_reset();
    request(0, 13'h011, 64'h1000, 8'd7);
    #1;
    n_cmp++; if (m0_arready !== 1'b1 || m1_arready !== 1'b0 || s_arvalid !== 1'b0)
      begin n_err++; $display("FAIL single_grant_cycle: m0_ar=%b m1_ar=%b s_arvalid=%b, required 1 0 0", m0_arready, m1_arready, s_arvalid); end
    @(negedge clk);
    m0_arvalid = 1'b0;
    #1;
    n_cmp++; if (s_arvalid !== 1'b1 || s_araddr !== 64'h1000 || s_arlen !== 8'd7 || s_arid !== 13'h011)
      begin n_err++; $display("FAIL single_s_ar: valid=%b addr=%h len=%0d id=%h, required 1 1000 7 011", s_arvalid, s_araddr, s_arlen, s_arid); end
    n_cmp++; if (busy !== 1'b1 || grant !== 1'b0)
      begin n_err++; $display("FAIL single_busy_grant: busy=%b grant=%b, required 1 0", busy, grant); end
    serve(0, 0, 8, 99, 99, 64'hA0, 1'b0, 1'b0);
    bad = rx_bad(0, 64'hA0, 8);
    n_cmp++; if (bad !== 0)
      begin n_err++; $display("FAIL single_m0_beats: %0d bad beats, required 0", bad); end
    n_cmp++; if (rx1.size() !== 0 || bad_rv !== 0)
      begin n_err++; $display("FAIL single_m1_quiet: m1 beats=%0d stray rvalid=%0d, required 0 0", rx1.size(), bad_rv); end
    n_cmp++; if (pt_err !== 0)
      begin n_err++; $display("FAIL single_passthru: %0d field errors, required 0", pt_err); end
    #1;
    n_cmp++; if (busy !== 1'b0 || len_err !== 1'b0)
      begin n_err++; $display("FAIL single_end: busy=%b len_err=%b, required 0 0", busy, len_err); end
  endtask

  task automatic test_fairness();
    logic [63:0] exp_addr;
    int w, bad;
    do_reset();
    request(0, 13'h100, 64'h2000, 8'd1);
    request(1, 13'h101, 64'h3000, 8'd1);
    for (int k = 0; k < 3; k++) begin
      w = k % 2;
      #1;
      n_cmp++; if ((w == 0 ? m0_arready : m1_arready) !== 1'b1 || (w == 0 ? m1_arready : m0_arready) !== 1'b0)
        begin n_err++; $display("FAIL fair_pick_%0d: m0_ar=%b m1_ar=%b, required master %0d", k, m0_arready, m1_arready, w); end
      exp_addr = (w == 0) ? m0_araddr : m1_araddr;
      @(negedge clk);
      request(w, 13'(k), exp_addr + 64'h100, 8'd1);
      #1;
      n_cmp++; if (grant !== 1'(w) || s_araddr !== exp_addr)
        begin n_err++; $display("FAIL fair_grant_%0d: grant=%b addr=%h, required %0d %h", k, grant, s_araddr, w, exp_addr); end
      serve(w, 0, 2, 99, 99, 64'h40 * 64'(k), 1'b0, 1'b1);
      bad = rx_bad(w, 64'h40 * 64'(k), 2);
      n_cmp++; if (bad !== 0 || ar_seen !== 0)
        begin n_err++; $display("FAIL fair_burst_%0d: bad beats=%0d arready while busy=%0d, required 0 0", k, bad, ar_seen); end
    end
  endtask

  task automatic test_addr_hold();
    do_reset();
    request(0, 13'h022, 64'h5000, 8'd3);
    @(negedge clk);
    m0_arvalid = 1'b0;
    serve(0, 5, 4, 99, 99, 64'h10, 1'b1, 1'b0);
    n_cmp++; if (arv_cycles !== 6)
      begin n_err++; $display("FAIL hold_arvalid_cycles: got %0d, required 6", arv_cycles); end
    n_cmp++; if (addr_moved !== 1'b0 || ar_seen !== 0)
      begin n_err++; $display("FAIL hold_stable: addr_moved=%b arready pulses=%0d, required 0 0", addr_moved, ar_seen); end
    n_cmp++; if (rx_bad(0, 64'h10, 4) !== 0)
      begin n_err++; $display("FAIL hold_beats: %0d bad beats, required 0", rx_bad(0, 64'h10, 4)); end
  endtask

  task automatic test_backpressure();
    int bad;
    do_reset();
    request(1, 13'h033, 64'h7000, 8'd7);
    @(negedge clk);
    m1_arvalid = 1'b0;
    serve(1, 0, 8, 3, 4, 64'hA0, 1'b0, 1'b0);
    bad = rx_bad(1, 64'hA0, 8);
    n_cmp++; if (bad !== 0)
      begin n_err++; $display("FAIL bp_order: %0d bad beats, required 0", bad); end
    n_cmp++; if (rr_err !== 0)
      begin n_err++; $display("FAIL bp_rready_follow: %0d cycles off, required 0", rr_err); end
    n_cmp++; if (rx0.size() !== 0 || bad_rv !== 0 || pt_err !== 0)
      begin n_err++; $display("FAIL bp_isolation: m0 beats=%0d stray=%0d field errs=%0d, required 0", rx0.size(), bad_rv, pt_err); end
  endtask

  task automatic test_len_err();
    do_reset();
    request(0, 13'h044, 64'h8000, 8'd7);
    @(negedge clk);
    m0_arvalid = 1'b0;
    serve(0, 1, 5, 99, 99, 64'hB0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (len_err !== 1'b1 || busy !== 1'b0)
      begin n_err++; $display("FAIL short_burst: len_err=%b busy=%b, required 1 0", len_err, busy); end
    request(1, 13'h045, 64'h9000, 8'd3);
    @(negedge clk);
    m1_arvalid = 1'b0;
    serve(1, 0, 4, 99, 99, 64'hC0, 1'b0, 1'b0);
    #1;
    n_cmp++; if (len_err !== 1'b1)
      begin n_err++; $display("FAIL len_err_sticky: got %b, required 1", len_err); end
    do_reset();
    #1;
    n_cmp++; if (len_err !== 1'b0)
      begin n_err++; $display("FAIL len_err_reset: got %b, required 0", len_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    request(0, 13'h055, 64'hA000, 8'd0);
    @(negedge clk);
    m0_arvalid = 1'b0;
    serve(0, 0, 1, 99, 99, 64'h1, 1'b0, 1'b0);
    #1;
    n_cmp++; if (len_err !== 1'b0 || rx_bad(0, 64'h1, 1) !== 0)
      begin n_err++; $display("FAIL single_beat: len_err=%b bad=%0d, required 0 0", len_err, rx_bad(0, 64'h1, 1)); end
    request(1, 13'h056, 64'hB000, 8'd7);
    @(negedge clk);
    m1_arvalid = 1'b0;
    s_arready = 1'b1;
    @(negedge clk);
    s_arready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_rvalid = 1'b1; s_rdata = 64'(i); s_rlast = 1'b0; m1_rready = 1'b1;
      @(negedge clk);
    end
    s_rvalid = 1'b1; s_rdata = 64'd3;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || s_rready !== 1'b0 || m1_rvalid !== 1'b0 || s_arvalid !== 1'b0)
      begin n_err++; $display("FAIL midreset_idle: busy=%b s_rready=%b m1_rvalid=%b s_arvalid=%b, required 0", busy, s_rready, m1_rvalid, s_arvalid); end
    s_rvalid = 1'b0;
    request(0, 13'h057, 64'hC000, 8'd0);
    request(1, 13'h058, 64'hD000, 8'd0);
    #1;
    n_cmp++; if (m0_arready !== 1'b1 || m1_arready !== 1'b0)
      begin n_err++; $display("FAIL midreset_prio: m0_ar=%b m1_ar=%b, required 1 0", m0_arready, m1_arready); end
  endtask

  // Reference: pending requests per master, the winner is the lone requester or the one the
  // round-robin pointer names; the pointer then moves to the other master.
  task automatic test_random();
    bit          p0, p1;
    logic [63:0] a0, a1, base;
    logic [7:0]  l0, l1;
    logic [12:0] i0, i1;
    int          prio_m, w, nb, dly, lo, bad;
    do_reset();
    prio_m = 0; p0 = 1'b0; p1 = 1'b0;
    a0 = '0; a1 = '0; l0 = '0; l1 = '0; i0 = '0; i1 = '0;
    for (int k = 0; k < 14; k++) begin
      if (!p0 && $urandom_range(0, 1) == 1) begin
        p0 = 1'b1; a0 = {32'($urandom), 32'($urandom)}; l0 = 8'($urandom_range(0, 7)); i0 = 13'($urandom);
        request(0, i0, a0, l0);
      end
      if (!p1 && $urandom_range(0, 1) == 1) begin
        p1 = 1'b1; a1 = {32'($urandom), 32'($urandom)}; l1 = 8'($urandom_range(0, 7)); i1 = 13'($urandom);
        request(1, i1, a1, l1);
      end
      if (!p0 && !p1) begin
        p1 = 1'b1; a1 = {32'($urandom), 32'($urandom)}; l1 = 8'($urandom_range(0, 7)); i1 = 13'($urandom);
        request(1, i1, a1, l1);
      end
      w = (p0 && p1) ? prio_m : (p0 ? 0 : 1);
      #1;
      n_cmp++; if ((w == 0 ? m0_arready : m1_arready) !== 1'b1 || (w == 0 ? m1_arready : m0_arready) !== 1'b0)
        begin n_err++; $display("FAIL rand_pick_%0d: m0_ar=%b m1_ar=%b, required master %0d", k, m0_arready, m1_arready, w); end
      @(negedge clk);
      if (w == 0) begin p0 = 1'b0; m0_arvalid = 1'b0; end
      else        begin p1 = 1'b0; m1_arvalid = 1'b0; end
      #1;
      n_cmp++; if (grant !== 1'(w) || s_araddr !== (w == 0 ? a0 : a1) || s_arlen !== (w == 0 ? l0 : l1) || s_arid !== (w == 0 ? i0 : i1))
        begin n_err++; $display("FAIL rand_ar_%0d: grant=%b addr=%h len=%0d id=%h, required %0d %h %0d %h", k, grant, s_araddr, s_arlen, s_arid,
                                w, (w == 0 ? a0 : a1), (w == 0 ? l0 : l1), (w == 0 ? i0 : i1)); end
      base = {32'($urandom), 32'($urandom)};
      nb   = int'(w == 0 ? l0 : l1) + 1;
      dly  = $urandom_range(0, 3);
      lo   = $urandom_range(0, 7);
      serve(w, dly, nb, lo, lo + $urandom_range(0, 2), base, 1'b0, 1'b1);
      bad = rx_bad(w, base, nb);
      n_cmp++; if (bad !== 0 || (w == 0 ? rx1.size() : rx0.size()) !== 0)
        begin n_err++; $display("FAIL rand_beats_%0d: bad=%0d other-master beats=%0d, required 0 0", k, bad, (w == 0 ? rx1.size() : rx0.size())); end
      n_cmp++; if (arv_cycles !== dly + 1 || ar_seen !== 0 || bad_rv !== 0 || rr_err !== 0 || pt_err !== 0)
        begin n_err++; $display("FAIL rand_proto_%0d: arv=%0d(req %0d) ar_seen=%0d stray=%0d rr=%0d pt=%0d", k, arv_cycles, dly + 1, ar_seen, bad_rv, rr_err, pt_err); end
      prio_m = 1 - w;
    end
    #1;
    n_cmp++; if (len_err !== 1'b0)
      begin n_err++; $display("FAIL rand_len_err: got %b, required 0", len_err); end
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_single_m0();
    test_fairness();
    test_addr_hold();
    test_backpressure();
    test_len_err();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares one downstream AXI read port (AR/R channels) between two cache masters: m0 = Icache refill, m1 = Dcache refill.
- Sits between the cache refill FSMs and the memory-side AXI master port.
- Grants one burst at a time using round-robin priority. Routes every R beat of that burst back to the granted master.
- Checks each burst's beat count against its arlen.

Parameters:
ID_WIDTH, 13, AXI ID width (matches cache ports)
ADDR_WIDTH, 64, AXI address width
DATA_WIDTH, 64, AXI data width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
mN_arid  in  ID_WIDTH  master N request ID (N = 0, 1; each mN_ line is one port per master)
mN_araddr  in  ADDR_WIDTH  master N burst address
mN_arlen  in  8  master N beats minus 1
mN_arsize  in  3  master N beat size
mN_arburst  in  2  master N burst type
mN_arprot  in  3  master N protection bits
mN_arvalid  in  1  master N request valid
mN_arready  out  1  master N request accepted
mN_rid  out  ID_WIDTH  returned ID
mN_rdata  out  DATA_WIDTH  returned data
mN_rresp  out  2  returned response
mN_rlast  out  1  last beat
mN_rvalid  out  1  beat valid to master N
mN_rready  in  1  master N accepts beat
s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arprot  out  as above  registered downstream AR fields
s_arvalid  out  1  downstream request valid
s_arready  in  1  downstream accepts request
s_rid, s_rdata, s_rresp, s_rlast, s_rvalid  in  as above  downstream R beat
s_rready  out  1  downstream beat accepted
busy  out  1  high in any state other than IDLE
grant  out  1  index of the current or last granted master
len_err  out  1  sticky flag: rlast mismatched the expected beat count

Behaviour:
- Reset values: state = IDLE; prio = 0 (m0 wins the first tie); grant = 0; len_err = 0; beat_cnt = 0. All s_ar* fields = 0; s_arvalid = 0.
- Reset outputs: mN_arready = 0, mN_rvalid = 0, s_rready = 0, busy = 0.
- States: IDLE, ADDR, DATA.
- IDLE:
  - If only one mN_arvalid is high, select that master. If both are high, select the master given by prio.
  - In the same cycle: pulse mN_arready = 1 (combinational) for the selected master. Register its AR fields into s_ar*, set grant, clear beat_cnt, go to ADDR.
  - With no request, stay in IDLE.
- ADDR:
  - s_arvalid = 1 and s_ar* are held stable.
  - On s_arready, go to DATA. Otherwise hold; mN_arvalid changes are ignored.
- DATA:
  - For the granted master only: mG_rvalid = s_rvalid; mG_rid/rdata/rresp/rlast = s_r*; s_rready = mG_rready.
  - The non-granted master sees rvalid = 0. Its r data outputs are don't-care (drive 0).
  - Each handshake (s_rvalid & s_rready) increments beat_cnt (8-bit, wraps, no saturation).
  - On a handshake with s_rlast:
    - If beat_cnt != s_arlen, set len_err (sticky until reset).
    - prio <= ~grant; return to IDLE.
  - A beat-count overrun without rlast is tolerated. Only the rlast beat is checked.
- Latency: request to s_arvalid = 1 cycle. R path = 0 cycles (combinational pass-through).
- Outstanding requests: only one burst at a time. A new grant is possible in the cycle after the rlast beat.
- Fairness: with both masters requesting continuously, grants alternate m0, m1, m0, ...
- A request that arrives while busy waits; mN_arvalid must stay asserted per AXI.
- Reset mid-burst: drop immediately to IDLE and clear len_err. The downstream is reset in the same cycle, so in-flight beats are not drained.

Decomposition:
- Package axi_pkg: ar_req_t struct (id, addr, len, size, burst, prot), r_beat_t struct (id, data, resp, last), and the state enum {IDLE, ADDR, DATA}. Parameterised by the widths above.
- Sub-module rr_arb2: 2-way round-robin picker. Inputs: req[1:0], prio. Output: gnt index, valid.

Test Plan:
- m0 alone, araddr = 0x1000, arlen = 7, s_arready high -> s_arvalid 1 cycle after m0_arready; 8 beats reach m0 only; m1_rvalid stays 0; len_err = 0; back to IDLE after the rlast beat.
- m0 and m1 assert together from reset -> m0 granted first, then m1; a third simultaneous request is granted to m0 again.
- s_arready held low 5 cycles while m1 toggles its request -> s_araddr stays constant; s_arvalid stays 1 for 6 cycles; no m1_arready pulse.
- mG_rready deasserted on beats 3-4 -> s_rready follows it; no beat dropped or duplicated; rdata order preserved (0xA0..0xA7).
- arlen = 7 but rlast arrives on beat 5 -> len_err = 1 and stays 1 through the next clean burst; a reset clears it.
- reset asserted during DATA beat 4 -> the next cycle shows IDLE, busy = 0, s_rready = 0, prio = 0.
